// File: rtl/ahb_regbank_slave_if.sv
// ahb_regbank_slave_if: AHB-Lite bus signals between a master/output stage and the register-bank slave.
interface ahb_regbank_slave_if;
  logic        HSEL;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [3:0]  HPROT;
  logic        HREADY;
  logic [31:0] HWDATA;
  logic        HREADYOUT;
  logic        HRESP;
  logic [31:0] HRDATA;
  modport slave (
    input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HPROT, HREADY, HWDATA,
    output HREADYOUT, HRESP, HRDATA
  );
  modport master (
    output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HPROT, HREADY, HWDATA,
    input  HREADYOUT, HRESP, HRDATA
  );
endinterface

// File: rtl/ahb_regbank_slave.sv
// ahb_regbank_slave: AHB-Lite bank of NUM_REGS 32-bit registers with optional wait states and two-cycle ERROR.
// Define AHB_REGBANK_PRIV_WRITE_EN to reject unprivileged writes (HPROT[1]=0).
module ahb_regbank_slave #(
  parameter int WAIT_STATES = 0,
  parameter int NUM_REGS    = 16
) (
  input  logic HCLK,
  input  logic HRESETn,
  ahb_regbank_slave_if.slave bus
);
  localparam int IW = $clog2(NUM_REGS);
  typedef enum logic [1:0] {IDLE, WAIT, ERR1, ERR2} state_t;
  state_t          state_q, state_d;
  logic [2:0]      cnt_q, cnt_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [3:0]      be_q, be_d, be;
  logic            wr_q, wr_d, vld_q, vld_d;
  logic [31:0]     regs_q [NUM_REGS];
  logic            open_win, accept, err, priv_err, commit;
  logic            unused_ok;
  assign unused_ok = ^{bus.HADDR[31:12], bus.HTRANS[0], bus.HPROT};
`ifdef AHB_REGBANK_PRIV_WRITE_EN
  assign priv_err = bus.HWRITE && !bus.HPROT[1];
`else
  assign priv_err = 1'b0;
`endif
  // The last WAIT cycle is treated like IDLE so a queued address phase is not delayed.
  assign open_win = state_q == IDLE || state_q == ERR2 || (state_q == WAIT && cnt_q == 3'd0);
  assign accept   = open_win && bus.HSEL && bus.HTRANS[1] && bus.HREADY;
  assign err      = bus.HADDR[11:2] >= 10'(NUM_REGS) || bus.HSIZE > 3'd2 ||
                    (bus.HSIZE == 3'd2 && bus.HADDR[1:0] != 2'd0) ||
                    (bus.HSIZE == 3'd1 && bus.HADDR[0]) || priv_err;
  assign be       = bus.HSIZE == 3'd0 ? 4'b0001 << bus.HADDR[1:0] :
                    bus.HSIZE == 3'd1 ? (bus.HADDR[1] ? 4'b1100 : 4'b0011) : 4'b1111;
  assign commit   = state_q == IDLE && vld_q && wr_q;
  assign bus.HREADYOUT = state_q == IDLE || state_q == ERR2;
  assign bus.HRESP     = state_q == ERR1 || state_q == ERR2;
  assign bus.HRDATA    = (vld_q && !wr_q) ? regs_q[idx_q] : 32'd0;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    be_d    = be_q;
    wr_d    = wr_q;
    vld_d   = vld_q;
    if (state_q == ERR1) begin
      state_d = ERR2;
    end else if (state_q == WAIT && cnt_q != 3'd0) begin
      cnt_d = cnt_q - 3'd1;
    end else if (accept) begin
      idx_d   = bus.HADDR[2 +: IW];
      be_d    = be;
      wr_d    = bus.HWRITE;
      vld_d   = !err;
      state_d = err ? ERR1 : (WAIT_STATES > 0 ? WAIT : IDLE);
      cnt_d   = (!err && WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;
    end else begin
      state_d = IDLE;
      cnt_d   = 3'd0;
      vld_d   = state_q == WAIT ? vld_q : 1'b0;
    end
  end
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      be_q    <= '0;
      wr_q    <= 1'b0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      be_q    <= be_d;
      wr_q    <= wr_d;
      vld_q   <= vld_d;
    end
  end
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else if (commit) begin
      for (int b = 0; b < 4; b++) if (be_q[b]) regs_q[idx_q][8*b +: 8] <= bus.HWDATA[8*b +: 8];
    end
  end
endmodule

// File: tb/tb_ahb_regbank_slave.sv
// tb_ahb_regbank_slave: directed vector table plus hand-written sequences for two bank instances (0 and 2 wait states).
module tb_ahb_regbank_slave;
  logic HCLK = 1'b0;
  logic HRESETn = 1'b0;
  always #5 HCLK = ~HCLK;
  logic        sel = 1'b0, hsel = 1'b0, hwrite = 1'b0;
  logic [31:0] haddr = '0, hwdata = '0;
  logic [1:0]  htrans = 2'b00;
  logic [2:0]  hsize = 3'd2;
  logic [3:0]  hprot = 4'b0011;
  ahb_regbank_slave_if b0();
  ahb_regbank_slave_if b2();
  assign b0.HSEL = hsel & ~sel;
  assign b2.HSEL = hsel & sel;
  assign b0.HADDR = haddr;   assign b2.HADDR = haddr;
  assign b0.HTRANS = htrans; assign b2.HTRANS = htrans;
  assign b0.HWRITE = hwrite; assign b2.HWRITE = hwrite;
  assign b0.HSIZE = hsize;   assign b2.HSIZE = hsize;
  assign b0.HPROT = hprot;   assign b2.HPROT = hprot;
  assign b0.HWDATA = hwdata; assign b2.HWDATA = hwdata;
  assign b0.HREADY = b0.HREADYOUT;
  assign b2.HREADY = b2.HREADYOUT;
  ahb_regbank_slave #(.WAIT_STATES(0), .NUM_REGS(16)) dut0 (.HCLK(HCLK), .HRESETn(HRESETn), .bus(b0));
  ahb_regbank_slave #(.WAIT_STATES(2), .NUM_REGS(16)) dut2 (.HCLK(HCLK), .HRESETn(HRESETn), .bus(b2));
  logic        rdy, rsp;
  logic [31:0] rdat;
  assign rdy  = sel ? b2.HREADYOUT : b0.HREADYOUT;
  assign rsp  = sel ? b2.HRESP : b0.HRESP;
  assign rdat = sel ? b2.HRDATA : b0.HRDATA;
  int n_chk = 0, n_fail = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  // One non-pipelined transfer; records per-data-cycle HREADYOUT/HRESP history (bit 0 = first cycle).
  task automatic xfer(input logic s, input logic wr, input logic [31:0] a, input logic [2:0] sz,
                      input logic [3:0] pr, input logic [31:0] wd, output logic resp,
                      output logic [31:0] rd, output int cyc, output logic [7:0] rh, output logic [7:0] eh);
    sel = s; hsel = 1'b1; htrans = 2'b10; hwrite = wr; haddr = a; hsize = sz; hprot = pr;
    @(posedge HCLK); #1;
    hsel = 1'b0; htrans = 2'b00; hwdata = wd;
    cyc = 0; rh = '0; eh = '0; resp = 1'bx; rd = 'x;
    for (int i = 0; i < 16; i++) begin
      @(negedge HCLK);
      rh[cyc[2:0]] = rdy; eh[cyc[2:0]] = rsp; resp = rsp; rd = rdat;
      cyc++;
      if (rdy) break;
      @(posedge HCLK); #1;
    end
    if (!rdy) cyc = 99;
    @(posedge HCLK); #1;
  endtask
  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [3:0]  prot;
    logic [31:0] wdata;
    logic        exp_resp;
    logic [31:0] exp_rdata;
  } vec_t;
  vec_t v[32];
  int nv = 0;
  task automatic add(input logic wr, input logic [31:0] a, input logic [2:0] sz, input logic [3:0] pr,
                     input logic [31:0] wd, input logic er, input logic [31:0] rd);
    v[nv] = '{wr, a, sz, pr, wd, er, rd};
    nv++;
  endtask
  logic        r_resp;
  logic [31:0] r_data;
  int          r_cyc;
  logic [7:0]  r_rh, r_eh;
  initial begin
    add(1, 32'h0000_000C, 2, 4'b0011, 32'h1122_3344, 0, 32'h0);
    add(0, 32'h0000_000C, 2, 4'b0011, 32'h0,         0, 32'h1122_3344);
    add(1, 32'h0000_000E, 0, 4'b0011, 32'h00AA_0000, 0, 32'h0);
    add(0, 32'h0000_000C, 2, 4'b0011, 32'h0,         0, 32'h11AA_3344);
    add(1, 32'h0000_000D, 1, 4'b0011, 32'hFFFF_FFFF, 1, 32'h0);
    add(0, 32'h0000_000C, 2, 4'b0011, 32'h0,         0, 32'h11AA_3344);
    add(0, 32'h0000_0040, 2, 4'b0011, 32'h0,         1, 32'h0);
    add(1, 32'h0000_0010, 3, 4'b0011, 32'hFFFF_FFFF, 1, 32'h0);
    add(1, 32'h0000_0012, 2, 4'b0011, 32'hFFFF_FFFF, 1, 32'h0);
    add(1, 32'h0000_0012, 1, 4'b0011, 32'hBEEF_0000, 0, 32'h0);
    add(0, 32'h0000_0010, 2, 4'b0011, 32'h0,         0, 32'hBEEF_0000);
    add(1, 32'h0000_00FC, 2, 4'b0011, 32'hFFFF_FFFF, 1, 32'h0);
    add(1, 32'hABCD_F03C, 2, 4'b0011, 32'h5A5A_5A5A, 0, 32'h0);
    add(0, 32'h0000_003C, 2, 4'b0011, 32'h0,         0, 32'h5A5A_5A5A);
    add(1, 32'h0000_003F, 0, 4'b0011, 32'h7700_0000, 0, 32'h0);
    add(1, 32'h0000_003C, 1, 4'b0011, 32'h0000_1234, 0, 32'h0);
    add(0, 32'h0000_003C, 2, 4'b0011, 32'h0,         0, 32'h775A_1234);
`ifdef AHB_REGBANK_PRIV_WRITE_EN
    add(1, 32'h0000_0020, 2, 4'b0001, 32'hCAFE_F00D, 1, 32'h0);
    add(0, 32'h0000_0020, 2, 4'b0000, 32'h0,         0, 32'h0);
`else
    add(1, 32'h0000_0020, 2, 4'b0001, 32'hCAFE_F00D, 0, 32'h0);
    add(0, 32'h0000_0020, 2, 4'b0000, 32'h0,         0, 32'hCAFE_F00D);
`endif
    add(1, 32'h0000_0020, 2, 4'b0011, 32'h0BAD_F00D, 0, 32'h0);
    add(0, 32'h0000_0020, 2, 4'b0011, 32'h0,         0, 32'h0BAD_F00D);
    // Reset values.
    repeat (2) @(posedge HCLK);
    @(negedge HCLK);
    chk("rst0_ready", 32'(b0.HREADYOUT), 32'd1);
    chk("rst0_resp", 32'(b0.HRESP), 32'd0);
    chk("rst0_rdata", b0.HRDATA, 32'd0);
    chk("rst2_ready", 32'(b2.HREADYOUT), 32'd1);
    HRESETn = 1'b1;
    @(posedge HCLK); #1;
    for (int i = 0; i < nv; i++) begin
      xfer(1'b0, v[i].wr, v[i].addr, v[i].size, v[i].prot, v[i].wdata, r_resp, r_data, r_cyc, r_rh, r_eh);
      chk($sformatf("vec%0d_resp", i), 32'(r_resp), 32'(v[i].exp_resp));
      chk($sformatf("vec%0d_rdata", i), r_data, v[i].exp_rdata);
      chk($sformatf("vec%0d_cycles", i), 32'(r_cyc), v[i].exp_resp ? 32'd2 : 32'd1);
      if (v[i].exp_resp) chk($sformatf("vec%0d_err_hist", i), {24'd0, r_rh, r_eh} >> 0, {16'd0, 8'b10, 8'b11});
    end
    // Non-transfers: IDLE, BUSY and HSEL=0 must neither stall nor write.
    sel = 1'b0;
    for (int k = 0; k < 3; k++) begin
      hsel = (k != 2); htrans = k == 0 ? 2'b00 : k == 1 ? 2'b01 : 2'b10;
      hwrite = 1'b1; haddr = 32'h0000_000C; hsize = 3'd2;
      @(posedge HCLK); #1;
      hsel = 1'b0; htrans = 2'b00; hwdata = 32'hFFFF_FFFF;
      @(negedge HCLK);
      chk($sformatf("notx%0d_ready", k), {rdy, rsp}, 2'b10);
      @(posedge HCLK); #1;
    end
    xfer(1'b0, 1'b0, 32'h0000_000C, 3'd2, 4'b0011, 32'h0, r_resp, r_data, r_cyc, r_rh, r_eh);
    chk("notx_reg_kept", r_data, 32'h11AA_3344);
    // Back-to-back write then read, zero wait states.
    hsel = 1'b1; htrans = 2'b10; hwrite = 1'b1; haddr = 32'h0000_0004; hsize = 3'd2;
    @(posedge HCLK); #1;
    hwdata = 32'hDEAD_BEEF; hwrite = 1'b0;
    @(negedge HCLK);
    chk("b2b_wr_phase", {rdy, rsp}, 2'b10);
    @(posedge HCLK); #1;
    hsel = 1'b0; htrans = 2'b00;
    @(negedge HCLK);
    chk("b2b_rd_phase", {rdy, rsp}, 2'b10);
    chk("b2b_rd_data", rdat, 32'hDEAD_BEEF);
    @(posedge HCLK); #1;
    // Two wait states.
    xfer(1'b1, 1'b0, 32'h0000_0008, 3'd2, 4'b0011, 32'h0, r_resp, r_data, r_cyc, r_rh, r_eh);
    chk("ws2_rd_cycles", 32'(r_cyc), 32'd3);
    chk("ws2_rd_hist", {24'd0, r_rh}, 32'b100);
    chk("ws2_rd_resp", {24'd0, r_eh}, 32'd0);
    xfer(1'b1, 1'b1, 32'h0000_0008, 3'd2, 4'b0011, 32'h1234_5678, r_resp, r_data, r_cyc, r_rh, r_eh);
    chk("ws2_wr_cycles", 32'(r_cyc), 32'd3);
    xfer(1'b1, 1'b0, 32'h0000_0008, 3'd2, 4'b0011, 32'h0, r_resp, r_data, r_cyc, r_rh, r_eh);
    chk("ws2_rd_back", r_data, 32'h1234_5678);
    xfer(1'b1, 1'b0, 32'h0000_0040, 3'd2, 4'b0011, 32'h0, r_resp, r_data, r_cyc, r_rh, r_eh);
    chk("ws2_err_cycles", 32'(r_cyc), 32'd2);
    chk("ws2_err_hist", {16'd0, r_rh, r_eh}, {16'd0, 8'b10, 8'b11});
    // Reset in the middle of a WAIT data phase.
    sel = 1'b1; hsel = 1'b1; htrans = 2'b10; hwrite = 1'b0; haddr = 32'h0000_0008; hsize = 3'd2;
    @(posedge HCLK); #1;
    hsel = 1'b0; htrans = 2'b00;
    chk("rstw_in_wait", 32'(b2.HREADYOUT), 32'd0);
    #2 HRESETn = 1'b0;
    #1;
    chk("rstw_ready_now", {b2.HREADYOUT, b2.HRESP}, 2'b10);
    chk("rstw_rdata", b2.HRDATA, 32'd0);
    @(negedge HCLK);
    HRESETn = 1'b1;
    @(posedge HCLK); #1;
    for (int r = 0; r < 16; r++) begin
      xfer(1'b0, 1'b0, 32'(r * 4), 3'd2, 4'b0011, 32'h0, r_resp, r_data, r_cyc, r_rh, r_eh);
      chk($sformatf("post_rst_reg%0d", r), r_data, 32'd0);
    end
    xfer(1'b1, 1'b0, 32'h0000_0008, 3'd2, 4'b0011, 32'h0, r_resp, r_data, r_cyc, r_rh, r_eh);
    chk("post_rst_ws2_reg2", r_data, 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
